rgb_fade_sequencer: RTL
=======================

# rgb_fade_sequencer

Command-driven colour sequencer that sits directly upstream of the RGB PWM driver and produces its three duty-cycle words. The block accepts colour commands over a valid/ready handshake. A command sets the LED colour immediately, ramps it linearly to a target colour at a fixed step rate, or blinks it between the target colour and off. Game logic issues short commands such as "fade to P1 colour" or "blink winner colour" and never manages PWM timing itself.

## Interface

- R, 8, duty resolution; duty words are R+1 bits; full-on value FULL = 2^R
- TICK_DIV, 100000, clk cycles per fade/blink tick (≥2)
- STEP, 4, duty increment per channel per fade tick (1..FULL)
- BLINK_TICKS, 25, ticks per blink half-period (≥1)

- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_mode  in  2  00 immediate, 01 fade, 10 blink, 11 reserved (treated as 00)
- cmd_red, cmd_green, cmd_blue  in  R+1 each  target duty per channel
- red_duty, green_duty, blue_duty  out  R+1 each  registered duty words to the PWM driver
- busy  out  1  high in FADE or BLINK
- done  out  1  one-cycle pulse when an immediate set is applied or a fade reaches target

## Operation

- States: IDLE, FADE, BLINK.
- Accept: a command is accepted on a rising clk edge where cmd_valid & cmd_ready. cmd_ready = 1 in IDLE and BLINK, 0 in FADE.
- Capture: on accept, targets are latched. Any component > FULL is clamped to FULL. The tick counter and blink counter restart at 0.
- Tick: the counter runs 0..TICK_DIV-1 and pulses tick on the cycle it equals TICK_DIV-1, then wraps. It runs continuously and restarts only on accept.
- Immediate (00/11): on the accept edge, duties ← clamped target, done pulses, state → IDLE.
- Fade (01): state → FADE on accept; duties are unchanged at accept. On each tick, each channel moves toward its own target:
  - if cur < tgt: cur ← min(cur+STEP, tgt)
  - if cur > tgt: cur ← max(cur−STEP, tgt)
  - intermediate arithmetic is R+2 bits, so no wrap-around is possible
- Fade completion: when all three channels equal their targets after an update, state → IDLE and done pulses on that cycle. A fade command whose target already equals the current duties completes on the first tick.
- Blink (10): on accept, duties ← target and state → BLINK. Every BLINK_TICKS ticks the outputs toggle between target and all-zero. Blink continues indefinitely and never pulses done.
- Command during BLINK: accepted; the new command fully replaces blink behaviour. A fade started from BLINK begins from whatever duties are currently displayed (target or zero).
- cmd_valid while in FADE: ignored, because cmd_ready = 0. A requester holding cmd_valid is accepted on the cycle after done.
- busy = (state != IDLE).

## Timing

- Reset values: all duties 0, state IDLE, cmd_ready 1, busy 0, done 0, all counters 0.
- Reset asserted mid-fade or mid-blink: everything returns to the reset values immediately (asynchronously). No done pulse is produced.
- Immediate latency: duties change and done pulses one clk after the accept edge, i.e. they are visible in the cycle following acceptance.
- Fade timing: the first update occurs TICK_DIV cycles after the accept edge; later updates follow every TICK_DIV cycles.
- Fade duration: ceil(max channel distance / STEP) ticks.
- Blink timing: the first toggle to zero occurs BLINK_TICKS×TICK_DIV cycles after accept.
- done and busy are registered. In FADE completion, done=1 in the same cycle busy falls to 0 and cmd_ready rises to 1.
- All outputs are registered; no combinational path from inputs to outputs, except that cmd_ready depends on state only.

## Test plan

Bench parameters: R=8, TICK_DIV=4, STEP=16, BLINK_TICKS=2.

- Reset → all duties 0, cmd_ready=1, busy=0; hold 10 cycles → no change.
- Immediate (00), rgb=(100,511,3) → next cycle duties=(100,256,3), single done pulse, busy=0.
- Fade (01) from 0 to (256,0,40) → blue 16,32,40 at ticks 1–3 (cycles 4,8,12 after accept); red reaches 256 at tick 16 (cycle 64); done pulses at cycle 64; cmd_ready=0 throughout the fade.
- Fade down from 256 to 250 → 250 after tick 1, done at cycle 4; a second command held valid during the fade → accepted on the cycle after done.
- Blink (10) to (0,128,0) → green 128, then 0 at cycle 8, then 128 at cycle 16; an immediate command issued at cycle 10 → accepted, blink stops, duties = new target.
- Reset pulse at tick 5 of a 0→256 fade → duties 0 immediately, state IDLE, no done pulse.

Source files
------------

// File: rtl/rgb_fade_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rgb_fade_sequencer
// Purpose  : Command-driven colour sequencer feeding an RGB PWM driver.
//            Accepts immediate-set, linear-fade and blink commands over a
//            valid/ready handshake and produces three registered duty words.
// Ports    : clk, reset (async, active high)
//            cmd_valid/cmd_ready, cmd_mode[1:0], cmd_red/green/blue[R:0]
//            red_duty/green_duty/blue_duty[R:0], busy, done
// Revision : 1.0 - initial release
// ============================================================================
module rgb_fade_sequencer #(
    parameter int R           = 8,
    parameter int TICK_DIV    = 100000,
    parameter int STEP        = 4,
    parameter int BLINK_TICKS = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [R:0] cmd_red,
    input  logic [R:0] cmd_green,
    input  logic [R:0] cmd_blue,
    output logic [R:0] red_duty,
    output logic [R:0] green_duty,
    output logic [R:0] blue_duty,
    output logic       busy,
    output logic       done
);

    localparam int c_tick_w  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int c_blink_w = $clog2(BLINK_TICKS + 1);

    localparam logic [c_tick_w-1:0]  c_tick_last  = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_TICKS - 1);
    localparam logic [R:0]           c_full       = {1'b1, {R{1'b0}}};

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fade  = 2'd1;
    localparam logic [1:0] c_st_blink = 2'd2;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [R:0] f_clamp(input logic [R:0] v);
        return (v > c_full) ? c_full : v;
    endfunction

    // One fade step toward the target, evaluated one bit wider than the duty
    // word so neither the add nor the subtract can wrap.
    function automatic logic [R:0] f_step(input logic [R:0] cur, input logic [R:0] tgt);
        logic [R+1:0] cur_x;
        logic [R+1:0] tgt_x;
        logic [R+1:0] stp_x;
        logic [R+1:0] res_x;
        cur_x = {1'b0, cur};
        tgt_x = {1'b0, tgt};
        stp_x = (R+2)'(STEP);
        if (cur_x < tgt_x) begin
            res_x = (cur_x + stp_x >= tgt_x) ? tgt_x : cur_x + stp_x;
        end else if (cur_x > tgt_x) begin
            res_x = (cur_x >= tgt_x + stp_x) ? cur_x - stp_x : tgt_x;
        end else begin
            res_x = cur_x;
        end
        return res_x[R:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [R:0]           r_red, r_green, r_blue;
    logic [R:0]           r_tgt_red, r_tgt_green, r_tgt_blue;
    logic [c_tick_w-1:0]  r_tick_cnt;
    logic [c_blink_w-1:0] r_blink_cnt;
    logic                 r_blink_on;
    logic                 r_done;
    logic                 r_busy;

    logic [1:0]           w_state_nxt;
    logic [R:0]           w_red_nxt, w_green_nxt, w_blue_nxt;
    logic [R:0]           w_tgt_red_nxt, w_tgt_green_nxt, w_tgt_blue_nxt;
    logic [c_tick_w-1:0]  w_tick_cnt_nxt;
    logic [c_blink_w-1:0] w_blink_cnt_nxt;
    logic                 w_blink_on_nxt;
    logic                 w_done_nxt;

    logic                 w_accept;
    logic                 w_tick;
    logic [R:0]           w_step_red, w_step_green, w_step_blue;

    assign cmd_ready  = (r_state != c_st_fade);
    assign w_accept   = cmd_valid & cmd_ready;
    assign w_tick     = (r_tick_cnt == c_tick_last);

    assign w_step_red   = f_step(r_red,   r_tgt_red);
    assign w_step_green = f_step(r_green, r_tgt_green);
    assign w_step_blue  = f_step(r_blue,  r_tgt_blue);

    assign red_duty   = r_red;
    assign green_duty = r_green;
    assign blue_duty  = r_blue;
    assign busy       = r_busy;
    assign done       = r_done;

    // ------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_red_nxt       = r_red;
        w_green_nxt     = r_green;
        w_blue_nxt      = r_blue;
        w_tgt_red_nxt   = r_tgt_red;
        w_tgt_green_nxt = r_tgt_green;
        w_tgt_blue_nxt  = r_tgt_blue;
        w_tick_cnt_nxt  = w_tick ? '0 : r_tick_cnt + c_tick_w'(1);
        w_blink_cnt_nxt = r_blink_cnt;
        w_blink_on_nxt  = r_blink_on;
        w_done_nxt      = 1'b0;

        if (w_accept) begin
            // Every accepted command restarts the tick and blink timing.
            w_tick_cnt_nxt  = '0;
            w_blink_cnt_nxt = '0;
            w_tgt_red_nxt   = f_clamp(cmd_red);
            w_tgt_green_nxt = f_clamp(cmd_green);
            w_tgt_blue_nxt  = f_clamp(cmd_blue);
            case (cmd_mode)
                2'b01: begin
                    w_state_nxt = c_st_fade;
                end
                2'b10: begin
                    w_state_nxt    = c_st_blink;
                    w_red_nxt      = f_clamp(cmd_red);
                    w_green_nxt    = f_clamp(cmd_green);
                    w_blue_nxt     = f_clamp(cmd_blue);
                    w_blink_on_nxt = 1'b1;
                end
                default: begin
                    // Immediate set; the reserved encoding behaves the same.
                    w_state_nxt = c_st_idle;
                    w_red_nxt   = f_clamp(cmd_red);
                    w_green_nxt = f_clamp(cmd_green);
                    w_blue_nxt  = f_clamp(cmd_blue);
                    w_done_nxt  = 1'b1;
                end
            endcase
        end else begin
            case (r_state)
                c_st_fade: begin
                    if (w_tick) begin
                        w_red_nxt   = w_step_red;
                        w_green_nxt = w_step_green;
                        w_blue_nxt  = w_step_blue;
                        if (w_step_red == r_tgt_red && w_step_green == r_tgt_green &&
                            w_step_blue == r_tgt_blue) begin
                            w_state_nxt = c_st_idle;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                c_st_blink: begin
                    if (w_tick) begin
                        if (r_blink_cnt == c_blink_last) begin
                            w_blink_cnt_nxt = '0;
                            w_blink_on_nxt  = ~r_blink_on;
                            w_red_nxt       = r_blink_on ? '0 : r_tgt_red;
                            w_green_nxt     = r_blink_on ? '0 : r_tgt_green;
                            w_blue_nxt      = r_blink_on ? '0 : r_tgt_blue;
                        end else begin
                            w_blink_cnt_nxt = r_blink_cnt + c_blink_w'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_red       <= '0;
            r_green     <= '0;
            r_blue      <= '0;
            r_tgt_red   <= '0;
            r_tgt_green <= '0;
            r_tgt_blue  <= '0;
            r_tick_cnt  <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_red       <= w_red_nxt;
            r_green     <= w_green_nxt;
            r_blue      <= w_blue_nxt;
            r_tgt_red   <= w_tgt_red_nxt;
            r_tgt_green <= w_tgt_green_nxt;
            r_tgt_blue  <= w_tgt_blue_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_on  <= w_blink_on_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= (w_state_nxt != c_st_idle);
        end
    end

endmodule
`default_nettype wire
